kmeans_core: RTL

KMEANS_CORE -- requirements
Module: kmeans_core

---
 rtl/kmeans_core.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/kmeans_core.sv
// K-means clustering engine: one burst loads K centroids and N points, then
// assign/update passes run (shared sequential divider) until stable or MAX_ITER.
module kmeans_core #(
    parameter int K        = 4,
    parameter int N        = 4096,
    parameter int W        = 8,
    parameter int MAX_ITER = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [2*W-1:0] in_data,
    input  logic           mode,
    output logic           busy,
    output logic           out_valid,
    output logic [2*W-1:0] out_data,
    output logic [7:0]     out_iter,
    output logic           out_last
);
    localparam int AW  = (N > 1) ? $clog2(N) : 1;
    localparam int SW  = W + $clog2(N);
    localparam int CW  = $clog2(N) + 1;
    localparam int IW  = (K > 1) ? $clog2(K) : 1;
    localparam int OW  = IW + 1;
    localparam int LW  = (AW > IW) ? AW : IW;
    localparam int DW  = 2 * W + 1;
    localparam int STW = $clog2(SW);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_CENT, S_LOAD_DATA, S_ASSIGN, S_UPDATE, S_OUTPUT
    } state_t;

    state_t          r_state;
    logic            r_busy, r_out_valid, r_out_last, r_mode;
    logic [2*W-1:0]  r_out_data;
    logic [7:0]      r_out_iter, r_iter;
    logic [LW-1:0]   r_lcnt;
    logic [AW-1:0]   r_rd_addr;
    logic            r_issue, r_v1, r_v2;
    logic [IW-1:0]   r_win, r_ucl;
    logic [2*W-1:0]  r_pt, r_rd_data;
    logic            r_udim, r_dbusy, r_changed;
    logic [SW-1:0]   r_dquo;
    logic [CW-1:0]   r_drem;
    logic [STW-1:0]  r_dstep;
    logic [OW-1:0]   r_ocnt;
    logic [2*W-1:0]  r_cent  [K];
    logic [SW-1:0]   r_sum_x [K];
    logic [SW-1:0]   r_sum_y [K];
    logic [CW-1:0]   r_count [K];
    logic [2*W-1:0]  r_mem   [N];

    logic [W-1:0]    w_px, w_py;
    logic [DW-1:0]   w_dist [K];
    logic [DW-1:0]   w_best;
    logic [IW-1:0]   w_win;

    assign w_px = r_rd_data[2*W-1:W];
    assign w_py = r_rd_data[W-1:0];

    for (genvar gi = 0; gi < K; gi++) begin : g_dist
        logic [W-1:0] w_cx, w_cy, w_dx, w_dy;
        assign w_cx = r_cent[gi][2*W-1:W];
        assign w_cy = r_cent[gi][W-1:0];
        assign w_dx = (w_px >= w_cx) ? (w_px - w_cx) : (w_cx - w_px);
        assign w_dy = (w_py >= w_cy) ? (w_py - w_cy) : (w_cy - w_py);
        assign w_dist[gi] = r_mode ? (DW'(w_dx) * DW'(w_dx) + DW'(w_dy) * DW'(w_dy))
                                   : (DW'(w_dx) + DW'(w_dy));
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_win  = '0;
        w_best = w_dist[0];
        for (int i = 1; i < K; i++) begin
            if (w_dist[i] < w_best) begin
                w_best = w_dist[i];
                w_win  = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD_DATA && in_valid)
            r_mem[r_lcnt[AW-1:0]] <= in_data;
        r_rd_data <= r_mem[r_rd_addr];
    end

    // Restoring divider: one quotient bit per cycle, x then y per cluster.
    logic [SW-1:0]  w_dividend, w_qnew;
    logic [CW-1:0]  w_ucount, w_rem_next;
    logic [CW:0]    w_rem_sh, w_rem_sub;
    logic           w_qbit, w_div_last, w_chg, w_cl_done;
    logic [W-1:0]   w_old_coord;
    logic [7:0]     w_iter_inc;

    assign w_ucount    = r_count[r_ucl];
    assign w_dividend  = r_udim ? r_sum_y[r_ucl] : r_sum_x[r_ucl];
    assign w_rem_sh    = {r_drem, r_dquo[SW-1]};
    assign w_rem_sub   = w_rem_sh - {1'b0, w_ucount};
    assign w_qbit      = (w_rem_sh >= {1'b0, w_ucount});
    assign w_rem_next  = CW'(w_qbit ? w_rem_sub : w_rem_sh);
    assign w_qnew      = {r_dquo[SW-2:0], w_qbit};
    assign w_old_coord = r_udim ? r_cent[r_ucl][W-1:0] : r_cent[r_ucl][2*W-1:W];
    assign w_div_last  = r_dbusy && (r_dstep == STW'(SW - 1));
    assign w_chg       = r_changed | (w_div_last && (w_qnew[W-1:0] != w_old_coord));
    assign w_cl_done   = (!r_dbusy && w_ucount == '0) || (w_div_last && r_udim);
    assign w_iter_inc  = r_iter + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_iter  <= '0;
            r_out_last  <= 1'b0;
            r_mode      <= 1'b0;
            r_iter      <= '0;
            r_lcnt      <= '0;
            r_rd_addr   <= '0;
            r_issue     <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_win       <= '0;
            r_pt        <= '0;
            r_ucl       <= '0;
            r_udim      <= 1'b0;
            r_dbusy     <= 1'b0;
            r_changed   <= 1'b0;
            r_dquo      <= '0;
            r_drem      <= '0;
            r_dstep     <= '0;
            r_ocnt      <= '0;
            for (int i = 0; i < K; i++) begin
                r_cent[i]  <= '0;
                r_sum_x[i] <= '0;
                r_sum_y[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cent[0] <= in_data;
                        r_mode    <= mode;
                        r_lcnt    <= LW'(1);
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD_CENT;
                    end
                end
                S_LOAD_CENT: begin
                    if (in_valid) begin
                        r_cent[r_lcnt[IW-1:0]] <= in_data;
                        if (r_lcnt == LW'(K - 1)) begin
                            r_lcnt  <= '0;
                            r_state <= S_LOAD_DATA;
                        end else begin
                            r_lcnt <= r_lcnt + LW'(1);
                        end
                    end
                end
                S_LOAD_DATA: begin
                    if (in_valid) begin
                        if (r_lcnt == LW'(N - 1)) begin
                            r_lcnt    <= '0;
                            r_iter    <= '0;
                            r_rd_addr <= '0;
                            r_issue   <= 1'b1;
                            r_v1      <= 1'b0;
                            r_v2      <= 1'b0;
                            r_changed <= 1'b0;
                            r_state   <= S_ASSIGN;
                            for (int i = 0; i < K; i++) begin
                                r_sum_x[i] <= '0;
                                r_sum_y[i] <= '0;
                                r_count[i] <= '0;
                            end
                        end else begin
                            r_lcnt <= r_lcnt + LW'(1);
                        end
                    end
                end
                S_ASSIGN: begin
                    // Read -> distance/winner -> accumulate, drained before UPDATE.
                    r_v1  <= r_issue;
                    r_v2  <= r_v1;
                    r_win <= w_win;
                    r_pt  <= r_rd_data;
                    if (r_issue) begin
                        if (r_rd_addr == AW'(N - 1))
                            r_issue <= 1'b0;
                        else
                            r_rd_addr <= r_rd_addr + AW'(1);
                    end
                    if (r_v2) begin
                        r_sum_x[r_win] <= r_sum_x[r_win] + SW'(r_pt[2*W-1:W]);
                        r_sum_y[r_win] <= r_sum_y[r_win] + SW'(r_pt[W-1:0]);
                        r_count[r_win] <= r_count[r_win] + CW'(1);
                    end
                    if (!r_issue && !r_v1 && !r_v2) begin
                        r_ucl   <= '0;
                        r_udim  <= 1'b0;
                        r_dbusy <= 1'b0;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!r_dbusy) begin
                        if (w_ucount != '0) begin
                            r_dbusy <= 1'b1;
                            r_dquo  <= w_dividend;
                            r_drem  <= '0;
                            r_dstep <= '0;
                        end
                    end else begin
                        r_dquo  <= w_qnew;
                        r_drem  <= w_rem_next;
                        r_dstep <= r_dstep + STW'(1);
                        if (w_div_last) begin
                            r_dbusy   <= 1'b0;
                            r_udim    <= ~r_udim;
                            r_changed <= w_chg;
                            if (r_udim)
                                r_cent[r_ucl][W-1:0] <= w_qnew[W-1:0];
                            else
                                r_cent[r_ucl][2*W-1:W] <= w_qnew[W-1:0];
                        end
                    end
                    if (w_cl_done) begin
                        if (r_ucl == IW'(K - 1)) begin
                            r_ucl     <= '0;
                            r_iter    <= w_iter_inc;
                            r_changed <= 1'b0;
                            if (!w_chg || w_iter_inc == 8'(MAX_ITER)) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_cent[0];
                                r_out_iter  <= w_iter_inc;
                                r_out_last  <= 1'b0;
                                r_ocnt      <= OW'(1);
                                r_state     <= S_OUTPUT;
                            end else begin
                                r_rd_addr <= '0;
                                r_issue   <= 1'b1;
                                r_v1      <= 1'b0;
                                r_v2      <= 1'b0;
                                r_state   <= S_ASSIGN;
                                for (int i = 0; i < K; i++) begin
                                    r_sum_x[i] <= '0;
                                    r_sum_y[i] <= '0;
                                    r_count[i] <= '0;
                                end
                            end
                        end else begin
                            r_ucl <= r_ucl + IW'(1);
                        end
                    end
                end
                S_OUTPUT: begin
                    if (r_ocnt == OW'(K)) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_out_iter  <= '0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_data <= r_cent[r_ocnt[IW-1:0]];
                        r_out_last <= (r_ocnt == OW'(K - 1));
                        r_ocnt     <= r_ocnt + OW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_iter  = r_out_iter;
    assign out_last  = r_out_last;
endmodule
